// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Ports: clk, rst_n (sync, active-low); start/op/a/b issue an operation;
//   flush aborts it; hi_we/lo_we/wdata are MTHI/MTLO writes (idle only);
//   busy flags an operation in flight, done pulses when HI/LO load;
//   hi/lo are the architectural registers.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic                 div_q, div_d;
   logic                 pneg_q, pneg_d;
   logic                 rneg_q, rneg_d;
   logic                 dz_q, dz_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 sgn;
   logic [WIDTH-1:0]     am, bm, addend;
   logic [WIDTH:0]       sum, shl;
   logic                 ge;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pneg_d  = pneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      m_d     = m_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      sgn = ~op[0];
      am  = (sgn && a[WIDTH-1]) ? -a : a;
      bm  = (sgn && b[WIDTH-1]) ? -b : b;

      // Multiply step: carry-out of the add becomes the new top bit
      addend = acc_q[0] ? m_q : '0;
      sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

      // Divide step: dividend bits stream out of acc low word
      shl = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      ge  = shl >= {1'b0, m_q};

      unique case (state_q)
         S_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start && !flush) begin
               state_d = S_CALC;
               cnt_d   = '0;
               div_d   = op[1];
               pneg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
               rneg_d  = sgn & a[WIDTH-1];
               dz_d    = op[1] & (b == '0);
               m_d     = op[1] ? bm : am;
               acc_d   = {{WIDTH{1'b0}}, (op[1] ? am : bm)};
               rem_d   = '0;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               if (div_q) begin
                  rem_d = ge ? shl - {1'b0, m_q} : shl;
                  acc_d = {acc_q[2*WIDTH-1:WIDTH],
                           acc_q[WIDTH-2:0], ge};
               end else begin
                  acc_d = {sum, acc_q[WIDTH-1:1]};
               end
               if (cnt_q == LAST) begin
                  state_d = S_FIX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               // First FIX cycle: sign correction in place.
               // Divide-by-zero keeps the all-ones quotient.
               cnt_d = 6'd1;
               if (div_q) begin
                  if (pneg_q && !dz_q)
                     acc_d[WIDTH-1:0] = -acc_q[WIDTH-1:0];
                  if (rneg_q)
                     rem_d = -rem_q;
               end else if (pneg_q) begin
                  acc_d = -acc_q;
               end
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
               hi_d    = div_q ? rem_q[WIDTH-1:0]
                               : acc_q[2*WIDTH-1:WIDTH];
               lo_d    = acc_q[WIDTH-1:0];
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         pneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         m_q     <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pneg_q  <= pneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the pipeline's EX stage. It accepts MULT/MULTU/DIV/DIVU issues alongside the single-cycle ALU and runs a fixed-latency shift-add or restoring-divide loop. While the loop runs it drives `busy` so hazard logic can stall dependent MFHI/MFLO. It owns the architectural HI/LO registers, including MTHI/MTLO writes.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `flush`  in  1  pipeline flush; aborts an in-flight operation.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.
- `hi`  out  WIDTH  HI register: product high word or remainder.
- `lo`  out  WIDTH  LO register: product low word or quotient.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - `start=1` and `flush=0`: latch `op`, take magnitudes of `a`/`b` (signed ops only) and record the result signs.
  - Result signs: product and quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the 6-bit iteration counter, then go to CALC.
- **CALC:** one iteration per cycle.
  - Multiply: conditional add of the multiplicand, then shift right across a 2·WIDTH accumulator.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor, set the quotient bit.
  - After `WIDTH` iterations (counter = WIDTH-1 at the edge), go to FIX.
- **FIX:**
  - Apply sign correction by two's-complement negation of the magnitude result, then load HI/LO.
  - Assert `done` for the following cycle and return to IDLE.
- **Widths:**
  - Magnitudes are WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
  - The product is 2·WIDTH bits.
  - The division remainder register is WIDTH+1 bits for the trial subtract.
- **Divide by zero (`b=0`, DIV or DIVU):** full latency is kept; result is `hi=a` (unmodified operand), `lo` = all ones. No exception.
- **Signed overflow (DIV 0x80000000 / 0xFFFFFFFF):** `lo=0x80000000`, `hi=0`. This falls out of the magnitude algorithm with WIDTH-bit wrap.
- **`start` while busy:** ignored; issue logic must hold the instruction until `busy=0`.
- **`flush` while busy:** go to IDLE on the next edge. HI/LO stay unchanged, no `done` pulse, `busy` low the next cycle.
- **`flush` together with `start` in IDLE:** `start` is ignored.
- **MTHI/MTLO:**
  - `hi_we`/`lo_we` take effect only when `busy=0`; they are ignored while busy.
  - In IDLE, a write and `start` in the same cycle are both honoured: the write lands now and is overwritten by the result 34 cycles later.
- **Reset (`rst_n=0` at an edge):** state=IDLE, `hi=0`, `lo=0`, `busy=0`, `done=0`, counter=0. Reset mid-operation discards the operation.

## Timing
- **Edge numbering:** E0 is the edge that samples `start`.
- **`busy`:** registered; high in the cycles after E0 through E33, low after E34.
- **Result edge E34:** HI/LO load, `done=1` for exactly the cycle after E34, `busy=0` in that same cycle. Latency is 34 cycles for all ops, including divide by zero.
- **Back-to-back issue:** the earliest next `start` is sampled at E35, while `done=1`.
- **Outputs:** `hi`/`lo` are register outputs; an MFHI/MFLO in the `done` cycle sees the new value.
- **MTHI/MTLO:** writes are visible the cycle after the write edge.
- **No combinational path from inputs to outputs.**

## Test plan
- **Signed multiply:** reset, then MULT a=0xFFFFFFFD (-3), b=5 -> at E34 `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `busy` high for exactly 34 cycles.
- **Unsigned multiply:** MULTU a=b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Then DIVU a=100, b=7 -> `lo`=0x0000000E, `hi`=0x00000002.
- **Signed divide:** DIV a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Overflow case DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIV a=0x12345678, b=0 -> at E34 `hi`=0x12345678, `lo`=0xFFFFFFFF.
- **Flush and busy-time writes:** start MULTU, pulse `flush` at cycle 10 -> `busy` low at cycle 11, no `done`, HI/LO retain old values. Assert `start` and `hi_we` during busy -> both ignored.
- **Reset and MTHI/MTLO:** `rst_n=0` at cycle 20 of a DIV -> `hi`=`lo`=0, `busy`=`done`=0. MTLO wdata=0xCAFEF00D in IDLE -> `lo`=0xCAFEF00D the next cycle.
